// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared FSM state encoding, protocol byte defaults, frame length and STATUS bit positions
package uart_alu_pkg;
  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC,
    SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT, SEND_NAK, WAIT_NAK
  } state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'hEE;
  localparam int FRAME_LEN = 5;
  localparam int STAT_ZERO = 0;
  localparam int STAT_OVF  = 1;
endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// frame_timer: inter-byte timeout counter for partial frames
//   i_clk/i_reset (async active-low), i_clear restarts the count, i_enable lets it run,
//   o_expired pulses on the last allowed cycle unless a clear arrives in that same cycle
module frame_timer #(
  parameter int NB_TIMER       = 20,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [NB_TIMER-1:0] r_cnt;
  logic                w_run;
  assign w_run     = i_enable && !i_clear;
  assign o_expired = w_run && (r_cnt == NB_TIMER'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) r_cnt <= '0;
    else          r_cnt <= w_run ? r_cnt + 1'b1 : '0;
endmodule

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects SYNC,OP,A,B,CHK frames from UART RX, drives the ALU, replies RESULT+STATUS or NAK via TX
//   i_clk, i_reset (async active-low); RX: i_rx_data/i_rx_done; TX: o_tx_start/o_tx_data/i_tx_done
//   ALU: o_alu_OP/o_alu_A/o_alu_B out, i_alu_res/i_alu_zero/i_alu_ovf in; o_busy, o_err_cnt (saturating)
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int                 NB_DATA        = 8,
  parameter int                 NB_ALU_OP      = 6,
  parameter logic [NB_DATA-1:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [NB_DATA-1:0] NAK_BYTE       = NAK_BYTE_DEF,
  parameter int                 TIMEOUT_CYCLES = 1_000_000,
  parameter int                 NB_TIMER       = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_res,
  input  logic                 i_alu_zero,
  input  logic                 i_alu_ovf,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic [NB_ALU_OP-1:0] o_alu_OP,
  output logic [NB_DATA-1:0]   o_alu_A,
  output logic [NB_DATA-1:0]   o_alu_B,
  output logic                 o_busy,
  output logic [7:0]           o_err_cnt
);
  state_t             r_state;
  logic [NB_DATA-1:0] r_op, r_a, r_b, r_status, w_status;
  logic               w_get, w_expired;
  logic [7:0]         w_err_next;
  assign w_get      = r_state inside {GET_OP, GET_A, GET_B, GET_CHK};
  assign o_busy     = r_state != IDLE;
  assign o_tx_start = r_state inside {SEND_RES, SEND_STAT, SEND_NAK};
  assign w_err_next = &o_err_cnt ? o_err_cnt : o_err_cnt + 8'd1;
  always_comb begin
    w_status            = '0;
    w_status[STAT_ZERO] = i_alu_zero;
    w_status[STAT_OVF]  = i_alu_ovf;
  end
  frame_timer #(.NB_TIMER(NB_TIMER), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done),
    .i_enable (w_get),
    .o_expired(w_expired)
  );
  // w_expired is already masked by i_rx_done, so a byte on the expiry cycle is taken normally
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_status  <= '0;
      o_tx_data <= '0;
      o_alu_OP  <= '0;
      o_alu_A   <= '0;
      o_alu_B   <= '0;
      o_err_cnt <= '0;
    end else if (w_expired) begin
      r_state   <= IDLE;
      o_err_cnt <= w_err_next;
    end else begin
      case (r_state)
        IDLE:    if (i_rx_done && i_rx_data == SYNC_BYTE) r_state <= GET_OP;
        GET_OP:  if (i_rx_done) begin r_op <= i_rx_data; r_state <= GET_A; end
        GET_A:   if (i_rx_done) begin r_a <= i_rx_data; r_state <= GET_B; end
        GET_B:   if (i_rx_done) begin r_b <= i_rx_data; r_state <= GET_CHK; end
        GET_CHK:
          if (i_rx_done) begin
            if (i_rx_data == (r_op ^ r_a ^ r_b)) begin
              o_alu_OP <= r_op[NB_ALU_OP-1:0];
              o_alu_A  <= r_a;
              o_alu_B  <= r_b;
              r_state  <= EXEC;
            end else begin
              o_tx_data <= NAK_BYTE;
              o_err_cnt <= w_err_next;
              r_state   <= SEND_NAK;
            end
          end
        EXEC: begin
          r_status  <= w_status;
          o_tx_data <= i_alu_res;
          r_state   <= SEND_RES;
        end
        SEND_RES:  r_state <= WAIT_RES;
        WAIT_RES:  if (i_tx_done) begin o_tx_data <= r_status; r_state <= SEND_STAT; end
        SEND_STAT: r_state <= WAIT_STAT;
        WAIT_STAT: if (i_tx_done) r_state <= IDLE;
        SEND_NAK:  r_state <= WAIT_NAK;
        WAIT_NAK:  if (i_tx_done) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: directed frames with a TX scoreboard queue checked on every o_tx_start
module tb_uart_alu_sequencer;
  import uart_alu_pkg::*;
  localparam int T = 40;
  logic       clk = 0, rst_n = 0;
  logic [7:0] rx_data = 0, alu_res, tx_data, alu_a, alu_b, err_cnt;
  logic       rx_done = 0, tx_done = 0, alu_zero, alu_ovf, tx_start, busy;
  logic [5:0] alu_op;
  logic [7:0] exp_q[$];
  int         n_err = 0, n_checks = 0;
  always #5 clk = ~clk;
  uart_alu_sequencer #(.TIMEOUT_CYCLES(T), .NB_TIMER(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_res(alu_res), .i_alu_zero(alu_zero), .i_alu_ovf(alu_ovf),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_alu_OP(alu_op), .o_alu_A(alu_a),
    .o_alu_B(alu_b), .o_busy(busy), .o_err_cnt(err_cnt)
  );
  // stand-in combinational ALU: 0x20 ADD, 0x22 SUB, signed overflow
  always_comb begin
    alu_res = 8'h00;
    alu_ovf = 1'b0;
    if (alu_op == 6'h20) begin
      alu_res = alu_a + alu_b;
      alu_ovf = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
    end else if (alu_op == 6'h22) begin
      alu_res = alu_a - alu_b;
      alu_ovf = (alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]);
    end
    alu_zero = alu_res == 8'h00;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (tx_start) begin
      if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1;
    tick;
    rx_done = 0;
  endtask
  task automatic frame(input logic [7:0] op, a, b, c);
    logic [7:0] f[FRAME_LEN];
    f = '{8'hA5, op, a, b, c};
    for (int i = 0; i < FRAME_LEN; i++) begin
      send_byte(f[i]);
      if (i < FRAME_LEN - 1) tick;
    end
  endtask
  task automatic tx_ack;
    tick;
    tx_done = 1;
    tick;
    tx_done = 0;
  endtask
  // entered in the EXEC cycle right after the CHK byte
  task automatic respond_good(input logic [7:0] op, a, b);
    chk("exec_op", alu_op, op);
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, b);
    chk("exec_nostart", tx_start, 0);
    tick;
    chk("res_start", tx_start, 1);
    tick;
    chk("res_pulse", tx_start, 0);
    tx_ack;
    chk("stat_start", tx_start, 1);
    tick;
    chk("stat_pulse", tx_start, 0);
    tx_ack;
    chk("idle_after", busy, 0);
    tick;
  endtask
  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    #21 rst_n = 1;
    tick;
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    frame(8'h20, 8'h05, 8'h03, 8'h26);
    respond_good(6'h20, 8'h05, 8'h03);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    frame(8'h22, 8'h07, 8'h07, 8'h22);
    respond_good(6'h22, 8'h07, 8'h07);
    chk("sub_err", err_cnt, 0);
    exp_q.push_back(8'hEE);
    frame(8'h20, 8'h05, 8'h03, 8'hFF);
    chk("nak_start", tx_start, 1);
    chk("nak_err", err_cnt, 1);
    chk("nak_alu_hold", {alu_op, alu_a, alu_b}, {6'h22, 8'h07, 8'h07});
    tick;
    chk("nak_pulse", tx_start, 0);
    tx_ack;
    chk("nak_idle", busy, 0);
    tick;
    send_byte(8'h11); tick;
    send_byte(8'h22); tick;
    chk("noise_idle", busy, 0);
    exp_q.push_back(8'h30); exp_q.push_back(8'h00);
    frame(8'h20, 8'h10, 8'h20, 8'h10);
    respond_good(6'h20, 8'h10, 8'h20);
    exp_q.push_back(8'h80); exp_q.push_back(8'h02);
    frame(8'h20, 8'h7F, 8'h01, 8'h5E);
    respond_good(6'h20, 8'h7F, 8'h01);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    frame(8'hE0, 8'h05, 8'h03, 8'hE6);
    respond_good(6'h20, 8'h05, 8'h03);
    send_byte(8'hA5); tick;
    send_byte(8'h20);
    repeat (T - 1) tick;
    chk("to_last_cycle_busy", busy, 1);
    tick;
    chk("to_idle", busy, 0);
    chk("to_err", err_cnt, 2);
    tick;
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    send_byte(8'hA5); tick;
    send_byte(8'h20);
    repeat (T - 1) tick;
    send_byte(8'h05);
    chk("to_race_busy", busy, 1);
    tick;
    send_byte(8'h03); tick;
    send_byte(8'h26);
    respond_good(6'h20, 8'h05, 8'h03);
    chk("to_race_err", err_cnt, 2);
    exp_q.push_back(8'h08);
    frame(8'h20, 8'h05, 8'h03, 8'h26);
    tick;
    tick;
    rst_n = 0;
    #1;
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
    #2 rst_n = 1;
    tick;
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    frame(8'h22, 8'h07, 8'h07, 8'h22);
    respond_good(6'h22, 8'h07, 8'h07);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_err", err_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Framed-command controller between the UART receive/transmit units and the combinational ALU. It collects a 5-byte command frame from the RX unit and verifies its checksum. It then drives the ALU operands, captures the result and flags, and returns a 2-byte response through the TX unit. It replaces free-running byte-to-operand loading with a sequenced, error-checked protocol and recovers from partial frames by timeout.

## Interface
- NB_DATA, 8, UART byte and ALU operand width
- NB_ALU_OP, 6, ALU opcode width (low bits of OP byte)
- SYNC_BYTE, 8'hA5, frame start marker
- NAK_BYTE, 8'hEE, reply on checksum failure
- TIMEOUT_CYCLES, 1_000_000, max clock cycles between bytes inside a frame (20 ms at 50 MHz)
- NB_TIMER, 20, timeout counter width

Ports:
- i_clk  in  1  system clock (50 MHz domain)
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid with i_rx_done
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when TX finished a byte
- i_alu_res  in  NB_DATA  ALU result
- i_alu_zero  in  1  ALU zero flag
- i_alu_ovf  in  1  ALU overflow flag
- o_tx_start  out  1  one-cycle TX start pulse
- o_tx_data  out  NB_DATA  byte to transmit, stable from start until i_tx_done
- o_alu_OP  out  NB_ALU_OP  ALU opcode
- o_alu_A  out  NB_DATA  operand A
- o_alu_B  out  NB_DATA  operand B
- o_busy  out  1  high in every state except IDLE
- o_err_cnt  out  8  saturating count of checksum and timeout errors

## Operation
- Frame: SYNC, OP, A, B, CHK; valid when CHK == OP ^ A ^ B (full 8-bit XOR; OP byte bits above NB_ALU_OP take part in the checksum but are dropped at the ALU).
- Response, good frame: RESULT byte, then STATUS = {6'b0, ovf, zero}. Bad checksum: single NAK_BYTE.
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT, SEND_NAK, WAIT_NAK.
- IDLE: rx byte == SYNC_BYTE -> GET_OP; other bytes ignored.
- GET_OP/GET_A/GET_B: store byte in shadow register, advance on i_rx_done.
- GET_CHK on i_rx_done: match -> load o_alu_* from shadows, go to EXEC. Mismatch -> SEND_NAK, err_cnt++. ALU outputs keep previous values.
- EXEC: capture i_alu_res, flags into status reg, o_tx_data <= result, go to SEND_RES.
- SEND_x: o_tx_start = 1, go to WAIT_x. WAIT_RES on i_tx_done: o_tx_data <= status, go to SEND_STAT. WAIT_STAT/WAIT_NAK on i_tx_done: go to IDLE.
- Timeout: in GET_* the timer clears on every i_rx_done and increments otherwise. Reaching TIMEOUT_CYCLES-1 -> IDLE, err_cnt++, no reply.
- i_rx_done outside IDLE/GET_* is dropped. i_tx_done outside WAIT_* is ignored.
- Simultaneous i_rx_done and timeout expiry: the byte wins, is accepted and clears the timer.
- err_cnt saturates at 8'hFF.
- Reset (any time, including mid-frame or mid-TX): state IDLE, and all outputs 0: o_tx_start, o_tx_data, o_alu_*, o_busy, o_err_cnt. Shadows and timer also clear.

## Timing
- All outputs are registered except o_tx_start and o_busy, which are pure state decodes.
- CHK i_rx_done sampled in cycle n: o_alu_* valid in n+1 (EXEC), result captured at end of n+1, o_tx_start high during n+2 only.
- i_tx_done in cycle m: o_tx_data = status from m+1, o_tx_start high during m+1.
- Bad CHK at n: o_tx_data = NAK_BYTE and o_tx_start high in n+1.
- Back-to-back frames: a SYNC byte is accepted from the cycle after WAIT_STAT/WAIT_NAK exits.

## Structure
- Shared package/header `uart_alu_pkg`: state encoding, SYNC_BYTE/NAK_BYTE defaults, FRAME_LEN=5, STATUS bit positions.
- Sub-module `frame_timer` (NB_TIMER, TIMEOUT_CYCLES): inputs i_clk, i_reset, i_clear, i_enable; output o_expired pulse.
- FSM plus datapath regs live in uart_alu_sequencer.

## Test plan
- ADD frame A5,20,05,03,26 -> o_alu_A=05, o_alu_B=03, OP=20. TX sends 08 then 00. o_tx_start pulses exactly twice, each after i_tx_done.
- SUB giving zero, A5,22,07,07,22 -> TX sends 00 then 01. err_cnt unchanged.
- Bad checksum A5,20,05,03,FF -> TX sends EE only, err_cnt=1, o_alu_* unchanged from prior frame.
- Noise 11,22 then valid frame -> noise ignored, normal reply.
- A5,20 then idle for TIMEOUT_CYCLES -> back to IDLE, o_busy=0, err_cnt++, no TX. Repeat with a byte arriving on the expiry cycle -> frame continues.
- Assert i_reset during WAIT_RES -> all outputs 0 immediately. Next valid frame is handled normally.
